// File: rtl/motion_sequencer.sv
// motion_sequencer: drive sequencer for the line-following car.
// Runs forward to the turn mark, dwells, coasts through a dead-time,
// reverses, and brakes at the home mark, with soft-start duty ramping
// and an emergency stop that overrides everything.
module motion_sequencer #(
   parameter int CNT_W     = 32,
   parameter int TURN_MARK = 6,
   parameter int HOME_MARK = 12,
   parameter int DWELL_CYC = 100,
   parameter int DEAD_CYC  = 16,
   parameter int DUTY_W    = 8,
   parameter int DUTY_MAX  = 255,
   parameter int RAMP_DIV  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              estop,
   input  logic [CNT_W-1:0]  lin,
   output logic [3:0]        direction,
   output logic              pwm_ctrl,
   output logic [DUTY_W-1:0] duty,
   output logic [2:0]        state,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FWD   = 3'd1,
      S_DWELL = 3'd2,
      S_DEAD  = 3'd3,
      S_REV   = 3'd4,
      S_HOME  = 3'd5,
      S_ESTOP = 3'd6
   } state_t;

   // One timer serves as dwell/dead counter or ramp divider depending on
   // the state; it only ever counts up to (limit - 1) before being cleared.
   localparam int TMR_TOP = (DWELL_CYC > DEAD_CYC) ?
                            ((DWELL_CYC > RAMP_DIV) ? DWELL_CYC : RAMP_DIV) :
                            ((DEAD_CYC  > RAMP_DIV) ? DEAD_CYC  : RAMP_DIV);
   localparam int TMR_W   = (TMR_TOP > 1) ? $clog2(TMR_TOP) : 1;

   localparam logic [TMR_W-1:0]  DWELL_LAST = TMR_W'(DWELL_CYC - 1);
   localparam logic [TMR_W-1:0]  DEAD_LAST  = TMR_W'(DEAD_CYC - 1);
   localparam logic [TMR_W-1:0]  RAMP_LAST  = TMR_W'(RAMP_DIV - 1);
   localparam logic [CNT_W-1:0]  TURN_L     = CNT_W'(TURN_MARK);
   localparam logic [CNT_W-1:0]  HOME_L     = CNT_W'(HOME_MARK);
   localparam logic [DUTY_W-1:0] DUTY_TOP   = DUTY_W'(DUTY_MAX);

   state_t              state_reg, state_next;
   logic [TMR_W-1:0]    tmr_reg, tmr_next;
   logic [DUTY_W-1:0]   duty_reg, duty_next;
   logic [3:0]          direction_reg, direction_next;
   logic                pwm_reg, pwm_next;
   logic                done_reg, done_next;

   // Next-state selection: estop first, then each state's own exit condition.
   always_comb begin
      state_next = state_reg;
      if (estop) begin
         state_next = S_ESTOP;
      end else begin
         case (state_reg)
            S_IDLE, S_HOME: if (start && (lin < TURN_L)) state_next = S_FWD;
            S_FWD:          if (lin >= TURN_L)           state_next = S_DWELL;
            S_DWELL:        if (tmr_reg == DWELL_LAST)   state_next = S_DEAD;
            S_DEAD:         if (tmr_reg == DEAD_LAST)    state_next = S_REV;
            S_REV:          if (lin >= HOME_L)           state_next = S_HOME;
            S_ESTOP:        state_next = S_IDLE;
            default:        state_next = S_IDLE;
         endcase
      end
   end

   // Timer and duty ramp: cleared on any state change, otherwise advanced.
   always_comb begin
      tmr_next  = '0;
      duty_next = '0;
      if (state_next == state_reg) begin
         case (state_reg)
            S_FWD, S_REV: begin
               duty_next = duty_reg;
               if (tmr_reg == RAMP_LAST) begin
                  tmr_next = '0;
                  if (duty_reg != DUTY_TOP) duty_next = duty_reg + 1'b1;
               end else begin
                  tmr_next = tmr_reg + 1'b1;
               end
            end
            S_DWELL, S_DEAD: tmr_next = tmr_reg + 1'b1;
            default:         tmr_next = '0;
         endcase
      end
   end

   // Bridge pattern, PWM enable and done decoded from the upcoming state so
   // they register on the same edge as the state itself.
   always_comb begin
      direction_next = 4'b0000;
      pwm_next       = 1'b0;
      done_next      = 1'b0;
      case (state_next)
         S_FWD:   begin direction_next = 4'b1010; pwm_next = 1'b1; end
         S_DWELL: direction_next = 4'b1010;
         S_REV:   begin direction_next = 4'b0101; pwm_next = 1'b1; end
         S_HOME:  done_next = 1'b1;
         default: ;
      endcase
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= S_IDLE;
         tmr_reg       <= '0;
         duty_reg      <= '0;
         direction_reg <= 4'b0000;
         pwm_reg       <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         tmr_reg       <= tmr_next;
         duty_reg      <= duty_next;
         direction_reg <= direction_next;
         pwm_reg       <= pwm_next;
         done_reg      <= done_next;
      end
   end

   assign state     = state_reg;
   assign direction = direction_reg;
   assign pwm_ctrl  = pwm_reg;
   assign duty      = duty_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_motion_sequencer.sv
// tb_motion_sequencer: two instances (default and short-timing/low-ceiling
// parameter sets) driven by directed then random stimulus and compared
// every clock against a time-stamp based behavioural model.
module tb_motion_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        estop = 1'b0;
   logic [31:0] lin = 32'd0;

   logic [3:0] dir0, dir1;
   logic       pwm0, pwm1, done0, done1;
   logic [7:0] duty0, duty1;
   logic [2:0] st0, st1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   motion_sequencer u0 (
      .clk(clk), .rst(rst), .start(start), .estop(estop), .lin(lin),
      .direction(dir0), .pwm_ctrl(pwm0), .duty(duty0), .state(st0), .done(done0)
   );

   motion_sequencer #(
      .DWELL_CYC(7), .DEAD_CYC(3), .DUTY_MAX(10), .RAMP_DIV(2)
   ) u1 (
      .clk(clk), .rst(rst), .start(start), .estop(estop), .lin(lin),
      .direction(dir1), .pwm_ctrl(pwm1), .duty(duty1), .state(st1), .done(done1)
   );

   // Model: current mode plus the clock number at which it was entered.
   typedef struct {
      int st; int entry;
      int turn; int home; int dwell; int dead; int dmax; int rdiv;
   } mdl_t;

   mdl_t m0, m1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic mdl_t step(mdl_t m, int n, bit s, bit e, bit r, logic [31:0] l);
      mdl_t q;
      int nx;
      int held;
      q = m;
      nx = m.st;
      held = n - m.entry;
      if (!r) begin
         q.st = 0;
         q.entry = n;
         return q;
      end
      if (e) nx = 6;
      else begin
         case (m.st)
            0, 5: if (s && l < 32'(m.turn)) nx = 1;
            1:    if (l >= 32'(m.turn)) nx = 2;
            2:    if (held == m.dwell) nx = 3;
            3:    if (held == m.dead) nx = 4;
            4:    if (l >= 32'(m.home)) nx = 5;
            default: nx = 0;
         endcase
      end
      if (nx != m.st) begin
         q.st = nx;
         q.entry = n;
      end
      return q;
   endfunction

   task automatic check_dut(input string who, input mdl_t m, input logic [2:0] st,
                            input logic [3:0] d, input logic p, input logic [7:0] du,
                            input logic dn);
      logic [3:0] ed;
      int eduty;
      ed = (m.st == 1 || m.st == 2) ? 4'b1010 : (m.st == 4) ? 4'b0101 : 4'b0000;
      eduty = 0;
      if (m.st == 1 || m.st == 4) begin
         eduty = (cyc - m.entry) / m.rdiv;
         if (eduty > m.dmax) eduty = m.dmax;
      end
      check({who, ".state"}, 32'(st), 32'(m.st));
      check({who, ".direction"}, 32'(d), 32'(ed));
      check({who, ".pwm_ctrl"}, 32'(p), 32'(m.st == 1 || m.st == 4));
      check({who, ".duty"}, 32'(du), 32'(eduty));
      check({who, ".done"}, 32'(dn), 32'(m.st == 5));
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      m0 = step(m0, cyc, start, estop, rst, lin);
      m1 = step(m1, cyc, start, estop, rst, lin);
      #1;
      check_dut("u0", m0, st0, dir0, pwm0, duty0, done0);
      check_dut("u1", m1, st1, dir1, pwm1, duty1, done1);
   endtask

   initial begin
      m0 = '{st: 0, entry: 0, turn: 6, home: 12, dwell: 100, dead: 16, dmax: 255, rdiv: 4};
      m1 = '{st: 0, entry: 0, turn: 6, home: 12, dwell: 7,   dead: 3,  dmax: 10,  rdiv: 2};

      $display("phase reset");
      repeat (2) tick();
      rst = 1'b1;
      tick();

      $display("phase normal run, skipped marks, ramp saturation");
      lin = 0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (79) tick();
      lin = 5; tick();
      lin = 7; tick();
      repeat (120) tick();
      lin = 11; repeat (30) tick();
      lin = 14; tick();
      repeat (3) tick();

      $display("phase start gating and estop mid-dwell");
      lin = 8; start = 1'b1;
      repeat (4) tick();
      lin = 0; tick();
      start = 1'b0; lin = 6; tick();
      repeat (49) tick();
      estop = 1'b1; repeat (2) tick();
      estop = 1'b0; tick();
      lin = 8; start = 1'b1; repeat (3) tick();
      lin = 0; tick();
      start = 1'b0; repeat (10) tick();

      $display("phase async reset mid-reverse");
      lin = 6;
      for (int i = 0; i < 300 && m0.st != 4; i++) tick();
      check("u0.reached_rev", 32'(st0), 32'd4);
      repeat (148) tick();
      check("u0.duty_before_reset", 32'(duty0), 32'd37);
      #2 rst = 1'b0;
      #1;
      m0.st = 0; m0.entry = cyc;
      m1.st = 0; m1.entry = cyc;
      check_dut("u0_async", m0, st0, dir0, pwm0, duty0, done0);
      check_dut("u1_async", m1, st1, dir1, pwm1, duty1, done1);
      #2 rst = 1'b1;
      lin = 0;
      repeat (5) tick();

      $display("phase random");
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 31) == 0) lin = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else lin = 32'($urandom_range(0, 15));
         end
         start = ($urandom_range(0, 3) == 0);
         estop = ($urandom_range(0, 99) == 0);
         rst   = ($urandom_range(0, 999) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/motion_sequencer.md
# motion_sequencer

Parametrised drive sequencer for the line-following car: turns a waypoint count from the track-mark counter into motor direction, PWM enable and a ramped duty request. A run goes forward to a turn mark, dwells, coasts through a dead-time, reverses, and brakes at the home mark. It adds start/emergency-stop control, soft-start duty ramping and direction-change dead-time. It sits between the mark counter and the PWM generator / H-bridge outputs.

## Interface
- CNT_W, 32, width of waypoint count `lin`
- TURN_MARK, 6, mark at which the car stops, dwells and reverses
- HOME_MARK, 12, mark at or beyond which the car brakes in reverse (must exceed TURN_MARK)
- DWELL_CYC, 100, clocks spent stopped at TURN_MARK (≥1)
- DEAD_CYC, 16, coast clocks with bridge off before reversing (≥1)
- DUTY_W, 8, duty request width
- DUTY_MAX, 255, ramp ceiling
- RAMP_DIV, 4, clocks per +1 duty step (≥1)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; begins a run when accepted
- estop  in  1  level; emergency stop, highest priority
- lin  in  CNT_W  current waypoint count, unsigned
- direction  out  4  H-bridge pattern
- pwm_ctrl  out  1  1 = PWM generator enabled
- duty  out  DUTY_W  duty request to PWM generator
- state  out  3  current state code
- done  out  1  high while in HOME

## Operation
- States and codes: IDLE=0, FWD=1, DWELL=2, DEAD=3, REV=4, HOME=5, ESTOP=6.
- Outputs per state (direction / pwm_ctrl): IDLE 0000/0; FWD 1010/1; DWELL 1010/0; DEAD 0000/0; REV 0101/1; HOME 0000/0; ESTOP 0000/0. done=1 only in HOME.
- duty=0 in all states except FWD and REV. On entry to FWD or REV, duty=0, then +1 every RAMP_DIV clocks, saturating at DUTY_MAX.
- IDLE or HOME -> FWD when start=1 and lin<TURN_MARK. Otherwise start is ignored.
- FWD -> DWELL when lin>=TURN_MARK. A skipped mark (count jumps past TURN_MARK) still triggers the transition.
- DWELL -> DEAD after exactly DWELL_CYC clocks in DWELL.
- DEAD -> REV after exactly DEAD_CYC clocks in DEAD.
- REV -> HOME when lin>=HOME_MARK.
- Any state -> ESTOP when estop=1. ESTOP -> IDLE on the first clock with estop=0. A dwell or dead-time in progress is abandoned, not resumed.
- Priority: estop over all other conditions, then the state's own transition.
- Dwell, dead and ramp counters clear on every state entry. Width is sized to the largest of DWELL_CYC, DEAD_CYC and RAMP_DIV.
- `lin` is compared unsigned at full CNT_W. It is sampled only; the block never modifies it.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, direction=0000, pwm_ctrl=0, duty=0, done=0, all counters 0. Release is synchronous to clk.
- All outputs are registered and change on the same edge as `state`. Conditions sampled at edge k appear on outputs after edge k, i.e. one-clock latency.
- DWELL persists for DWELL_CYC clocks; DEAD persists for DEAD_CYC clocks. pwm_ctrl is therefore 0 for DWELL_CYC+DEAD_CYC consecutive clocks between FWD and REV.
- Direction never changes from 1010 to 0101 without at least DEAD_CYC clocks of 0000 between them.
- The ramp reaches DUTY_MAX exactly DUTY_MAX×RAMP_DIV clocks after entering FWD or REV, and holds there.
- Reset asserted mid-run forces IDLE immediately, independent of clk. start must be presented again after release.

## Test plan
- Normal run (defaults): reset, lin=0, start=1 -> FWD, direction=1010, pwm_ctrl=1, duty 0→1 after 4 clocks; lin=6 -> DWELL, pwm_ctrl=0 for 100 clocks, DEAD 0000 for 16 clocks, then REV 0101 with duty restarting at 0; lin=12 -> HOME, done=1, duty=0.
- Skipped marks: in FWD, lin steps 5→7 -> DWELL entered. In REV, lin steps 11→14 -> HOME entered.
- Start gating: lin=8 with start=1 in IDLE -> stays IDLE. In HOME, set lin=0 with start=1 -> FWD.
- Estop mid-dwell: assert estop at dwell clock 50 -> ESTOP next edge, all outputs 0. Deassert -> IDLE. Restart -> FWD with fresh ramp.
- Ramp saturation (DUTY_MAX=10, RAMP_DIV=2): duty hits 10 at clock 20 of FWD and stays at 10 for ≥50 further clocks.
- Async reset mid-REV with duty=37: pull rst low between edges -> outputs 0 and state=IDLE before the next edge. Release -> remains IDLE until start.
